// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared opcodes, ALUOp encodings, NOP word and control bundle type
package if_id_stage_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;
    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;
endpackage

// File: rtl/id_control_decode.sv
// id_control_decode: opcode -> control bundle, sign-extended immediate, rs2 usage
//   instr    in  : instruction word held in IF/ID
//   ctrl     out : control bundle (ungated by valid)
//   imm      out : sign-extended immediate (0 for opcodes without one)
//   uses_rs2 out : instruction reads rs2 (R-type, store, branch)
module id_control_decode import if_id_stage_pkg::*; #(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic            uses_rs2
);
    logic [XLEN-1:0] imm_i, imm_s, imm_b;
    logic unused_bits;
    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign unused_bits = ^instr[19:12];
    always_comb begin
        ctrl     = '0;
        imm      = '0;
        uses_rs2 = 1'b0;
        case (instr[6:0])
            OP_R: begin
                ctrl     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT};
                uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT};
                imm  = imm_i;
            end
            OP_LOAD: begin
                ctrl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
                imm  = imm_i;
            end
            OP_STORE: begin
                ctrl     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
                imm      = imm_s;
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                ctrl     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_BR};
                imm      = imm_b;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID register with decode front-end, load-use hazard unit and event counters
//   clk, reset (async, active-low)
//   PC_in, instruction_in        : fetched PC and instruction
//   IDEX_MemRead, IDEX_rd        : load in EX and its destination
//   branch_taken                 : redirect from EX/MEM, squashes IF/ID
//   stall, Flush                 : PC/IF hold and ID/EX bubble request
//   PC_Out, instruction, rs1, rs2, rd, imm_data, control bits : decoded ID outputs
//   stall_count, flush_count     : saturating event counters
module if_id_stage import if_id_stage_pkg::*; #(
    parameter int          XLEN      = 64,
    parameter logic [31:0] NOP_INSTR = if_id_stage_pkg::NOP_INSTR,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  PC_in,
    input  logic [31:0]      instruction_in,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rd,
    input  logic             branch_taken,
    output logic             stall,
    output logic             Flush,
    output logic [XLEN-1:0]  PC_Out,
    output logic [3:0]       instruction,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  imm_data,
    output logic             ALUSrc,
    output logic             Branch,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic [1:0]       ALUOp,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            uses_rs2;
    logic            hazard;
    ctrl_t           ctrl, ctrl_v;

    id_control_decode #(.XLEN(XLEN)) u_decode (
        .instr    (instr_q),
        .ctrl     (ctrl),
        .imm      (imm_data),
        .uses_rs2 (uses_rs2)
    );

    // An invalid slot still holds the NOP word, but must never enable anything downstream
    assign ctrl_v = valid_q ? ctrl : '0;
    assign {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp} = ctrl_v;
    assign PC_Out      = pc_q;
    assign instruction = {instr_q[30], instr_q[14:12]};
    assign rs1         = instr_q[19:15];
    assign rs2         = instr_q[24:20];
    assign rd          = instr_q[11:7];

    assign hazard = valid_q & IDEX_MemRead & (IDEX_rd != 5'd0) &
                    ((IDEX_rd == rs1) | (uses_rs2 & (IDEX_rd == rs2)));
    // A taken branch squashes the dependent instruction anyway, so no stall is needed
    assign stall = hazard & ~branch_taken;
    assign Flush = hazard | branch_taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q     <= NOP_INSTR;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (branch_taken) begin
                instr_q <= NOP_INSTR;
                pc_q    <= '0;
                valid_q <= 1'b0;
            end else if (!stall) begin
                instr_q <= instruction_in;
                pc_q    <= PC_in;
                valid_q <= 1'b1;
            end
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (branch_taken && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: scoreboard bench for if_id_stage with a spec-level reference model
module tb_if_id_stage;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic [63:0] pc;
        logic [3:0]  ins;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [7:0]  ctrl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } obs_t;

    logic clk = 0;
    logic reset = 0;
    logic [63:0] PC_in = '0;
    logic [31:0] instruction_in = NOP;
    logic IDEX_MemRead = 0;
    logic [4:0] IDEX_rd = '0;
    logic branch_taken = 0;
    logic stall, Flush, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg;
    logic [63:0] PC_Out, imm_data;
    logic [3:0] instruction;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] ALUOp;
    logic [CNT_W-1:0] stall_count, flush_count;

    int checks = 0;
    int failures = 0;
    obs_t q[$];

    logic [31:0] m_instr = NOP;
    logic [63:0] m_pc = '0;
    bit m_valid = 0;
    int m_sc = 0;
    int m_fc = 0;

    always #5 clk = ~clk;

    if_id_stage #(.XLEN(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .PC_in(PC_in), .instruction_in(instruction_in),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd), .branch_taken(branch_taken),
        .stall(stall), .Flush(Flush), .PC_Out(PC_Out), .instruction(instruction),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm_data(imm_data), .ALUSrc(ALUSrc),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .ALUOp(ALUOp), .stall_count(stall_count), .flush_count(flush_count)
    );

    function automatic obs_t model_out(input logic mr, input logic [4:0] ird, input logic br);
        obs_t e;
        logic [6:0] op;
        logic [12:0] boff;
        bit use2, hz;
        op = m_instr[6:0];
        e = '0;
        e.pc  = m_pc;
        e.ins = {m_instr[30], m_instr[14:12]};
        e.rs1 = m_instr[19:15];
        e.rs2 = m_instr[24:20];
        e.rd  = m_instr[11:7];
        boff = {m_instr[31], m_instr[7], m_instr[30:25], m_instr[11:8], 1'b0};
        case (op)
            7'b0110011: e.ctrl = 8'b0010_0010;
            7'b0010011: begin e.ctrl = 8'b1010_0010; e.imm = 64'($signed(m_instr[31:20])); end
            7'b0000011: begin e.ctrl = 8'b1111_0000; e.imm = 64'($signed(m_instr[31:20])); end
            7'b0100011: begin e.ctrl = 8'b1000_1000; e.imm = 64'($signed({m_instr[31:25], m_instr[11:7]})); end
            7'b1100011: begin e.ctrl = 8'b0000_0101; e.imm = 64'($signed(boff)); end
            default: ;
        endcase
        if (!m_valid) e.ctrl = '0;
        use2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
        hz = m_valid && mr && ird != 0 && (ird == e.rs1 || (use2 && ird == e.rs2));
        e.stall = hz && !br;
        e.flush = hz || br;
        e.sc = CNT_W'(m_sc);
        e.fc = CNT_W'(m_fc);
        return e;
    endfunction

    task automatic step(input logic rst, input logic [63:0] pc, input logic [31:0] ins,
                        input logic mr, input logic [4:0] ird, input logic br);
        obs_t e;
        @(posedge clk);
        #1;
        reset = rst; PC_in = pc; instruction_in = ins;
        IDEX_MemRead = mr; IDEX_rd = ird; branch_taken = br;
        if (!rst) begin
            m_instr = NOP; m_pc = '0; m_valid = 0; m_sc = 0; m_fc = 0;
        end
        e = model_out(mr, ird, br);
        q.push_back(e);
        if (rst) begin
            if (e.stall) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
            if (br) m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
            if (br) begin
                m_instr = NOP; m_pc = '0; m_valid = 0;
            end else if (!e.stall) begin
                m_instr = ins; m_pc = pc; m_valid = 1;
            end
        end
    endtask

    task automatic spot(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        obs_t a, e;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {stall, Flush, PC_Out, instruction, rs1, rs2, rd, imm_data,
                 ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp,
                 stall_count, flush_count};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard @%0t: got %h expected %h", $time, a, e);
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0] ops[6];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
        r = $urandom;
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        r[6:0] = ops[$urandom_range(0, 5)];
        return r;
    endfunction

    initial begin
        step(0, 64'h0, NOP, 0, 0, 0);
        step(0, 64'h0, NOP, 0, 0, 0);
        @(negedge clk);
        spot("reset_stall_count", 64'(stall_count), 0);
        spot("reset_rd", 64'(rd), 0);
        step(1, 64'h40, 32'h00A30333, 0, 0, 0);
        step(1, 64'h44, 32'h006283B3, 0, 0, 0);
        @(negedge clk);
        spot("add_pc", PC_Out, 64'h40);
        spot("add_rd", 64'(rd), 6);
        spot("add_rs2", 64'(rs2), 10);
        spot("add_aluop", 64'(ALUOp), 2);
        step(1, 64'h48, NOP, 1, 5, 0);
        @(negedge clk);
        spot("loaduse_stall", 64'({stall, Flush}), 3);
        step(1, 64'h48, NOP, 0, 5, 0);
        @(negedge clk);
        spot("loaduse_hold_pc", PC_Out, 64'h44);
        spot("loaduse_count", 64'(stall_count), 1);
        step(1, 64'h4C, 32'h00500393, 1, 0, 0);
        step(1, 64'h50, 32'hFE20AE23, 1, 7, 0);
        @(negedge clk);
        spot("addi_no_hazard", 64'(stall), 0);
        step(1, 64'h54, 32'h00208463, 0, 0, 0);
        @(negedge clk);
        spot("sw_imm", imm_data, 64'hFFFFFFFFFFFFFFFC);
        step(1, 64'h58, 32'h006283B3, 0, 0, 0);
        @(negedge clk);
        spot("beq_imm", imm_data, 64'd8);
        step(1, 64'h5C, NOP, 0, 0, 0);
        step(1, 64'h60, NOP, 1, 5, 1);
        @(negedge clk);
        spot("br_vs_stall", 64'({stall, Flush}), 1);
        step(1, 64'h64, NOP, 0, 0, 0);
        @(negedge clk);
        spot("br_pc", PC_Out, 0);
        spot("br_flush_count", 64'(flush_count), 1);
        step(1, 64'h68, 32'h006283B3, 0, 0, 0);
        for (int i = 0; i < SAT + 3; i++) step(1, 64'h6C, NOP, 1, 5, 0);
        @(negedge clk);
        spot("stall_saturate", 64'(stall_count), SAT);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) != 0, 64'({$urandom, $urandom}), rand_instr(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 9) == 0);
        end
        step(1, 64'h0, NOP, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
